// File: rtl/step_sequencer_if.sv
// Control and output bundle between the control FSM and the step sequencer.
// The master drives playback/config controls; the slave returns triggers and position.
interface step_sequencer_if #(
  parameter int CHANNELS = 4,
  parameter int STEPS    = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW = $clog2(STEPS + 1);
  localparam int SW = $clog2(STEPS);

  logic                start;
  logic                stop;
  logic                one_shot;
  logic                load_bpm;
  logic [7:0]          bpm_in;
  logic                load_len;
  logic [LW-1:0]       len_in;
  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [STEPS-1:0]    wr_data;
  logic [CHANNELS-1:0] mute;

  logic [CHANNELS-1:0] trig;
  logic                step_pulse;
  logic [SW-1:0]       step_idx;
  logic                running;

  modport master (
    output start, stop, one_shot, load_bpm, bpm_in, load_len, len_in,
           wr_en, wr_chan, wr_data, mute,
    input  trig, step_pulse, step_idx, running
  );

  modport slave (
    input  start, stop, one_shot, load_bpm, bpm_in, load_len, len_in,
           wr_en, wr_chan, wr_data, mute,
    output trig, step_pulse, step_idx, running
  );
endinterface

// File: rtl/step_sequencer.sv
// Pattern sequencer with BPM-driven phase accumulator; emits one-cycle per-channel
// triggers on each sixteenth-note step, in loop or one-shot mode.
module step_sequencer #(
  parameter int CHANNELS  = 4,
  parameter int STEPS     = 8,
  parameter int CLK_HZ    = 50000000,
  parameter int BPM_RESET = 120
) (
  input  logic            clk,
  input  logic            reset,
  step_sequencer_if.slave bus
);
  localparam int LW = $clog2(STEPS + 1);
  localparam int SW = $clog2(STEPS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // A sixteenth note at bpm quarter-notes/min lasts CLK_HZ*15/bpm cycles.
  localparam longint        THRESH_L = longint'(CLK_HZ) * 15;
  localparam int            AW       = $clog2(THRESH_L + 256);
  localparam logic [AW-1:0] THRESH   = AW'(THRESH_L);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       acc, acc_nxt, acc_sum;
  logic [SW-1:0]       step_idx, idx_nxt;
  logic [7:0]          bpm;
  logic [LW-1:0]       len, len_eff;
  logic                at_last;
  logic                fire;
  logic [CHANNELS-1:0] trig, trig_nxt;
  logic                step_pulse;
  logic [STEPS-1:0]    pattern [CHANNELS];

  // Out-of-range lengths behave like a full pattern so step_idx never leaves the row.
  assign len_eff = (len == '0 || len > LW'(STEPS)) ? LW'(STEPS) : len;
  assign at_last = (LW'(step_idx) >= len_eff - 1'b1);
  // acc stays below THRESH, so acc+bpm always fits in AW bits.
  assign acc_sum = acc + AW'(bpm);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = step_idx;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = RUN;
          acc_nxt   = '0;
          idx_nxt   = '0;
          fire      = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          idx_nxt   = '0;
        end else if (acc_sum >= THRESH) begin
          if (at_last && bus.one_shot) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            acc_nxt = acc_sum - THRESH;
            idx_nxt = at_last ? '0 : step_idx + 1'b1;
            fire    = 1'b1;
          end
        end else begin
          acc_nxt = acc_sum;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reads the row as it stood before any same-edge write.
    for (int c = 0; c < CHANNELS; c++)
      trig_nxt[c] = fire & pattern[c][idx_nxt] & ~bus.mute[c];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      step_idx   <= '0;
      trig       <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      step_idx   <= idx_nxt;
      trig       <= trig_nxt;
      step_pulse <= fire;
    end
  end

  // NOTE: the pattern store is flop-based and reset, because a reset must clear every row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bpm <= 8'(BPM_RESET);
      len <= LW'(STEPS);
      for (int c = 0; c < CHANNELS; c++) pattern[c] <= '0;
    end else begin
      if (bus.load_bpm) bpm <= bus.bpm_in;
      if (bus.load_len) len <= bus.len_in;
      for (int c = 0; c < CHANNELS; c++)
        if (bus.wr_en && bus.wr_chan == CW'(c)) pattern[c] <= bus.wr_data;
    end
  end

  assign bus.trig       = trig;
  assign bus.step_pulse = step_pulse;
  assign bus.step_idx   = step_idx;
  assign bus.running    = (state == RUN);
endmodule
